// File: rtl/xgmii_frame_checker.sv
// xgmii_frame_checker: passive XGMII (4/8 lane) frame parser and checker.
// Emits a one-cycle record per closed frame plus saturating good/bad counters.
//
// Ports:
//   clk, rst_n    clock, async active-low reset
//   en_i          1 = parse, 0 = hold FSM in IDLE
//   clr_i         sync clear of both counters
//   xc_i, xd_i    XGMII control flags / data, lane 0 first
//   frame_done_o  record valid pulse
//   frame_len_o   bytes after SFD up to TERMINATE (saturating)
//   frame_err_o   [0] pre/SFD [1] short [2] long [3] ctrl [4] no term
//                 [5] FCS (only with FRAME_CRC_CHECK_EN)
//   good_cnt_o, bad_cnt_o  saturating frame counters
// Optional: `define FRAME_CRC_CHECK_EN builds the CRC-32 FCS check.

module xgmii_frame_checker #(
  parameter int LANES   = 8,
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en_i,
  input  logic               clr_i,
  input  logic [LANES-1:0]   xc_i,
  input  logic [8*LANES-1:0] xd_i,
  output logic               frame_done_o,
  output logic [15:0]        frame_len_o,
`ifdef FRAME_CRC_CHECK_EN
  output logic [5:0]         frame_err_o,
`else
  output logic [4:0]         frame_err_o,
`endif
  output logic [CNT_W-1:0]   good_cnt_o,
  output logic [CNT_W-1:0]   bad_cnt_o
);

`ifdef FRAME_CRC_CHECK_EN
  localparam int ERR_W = 6;
  // Reflected-register form of the 32'hC704DD7B residue.
  localparam logic [31:0] CRC_MAGIC = 32'hDEBB20E3;
`else
  localparam int ERR_W = 5;
`endif

  localparam logic [7:0]  C_START = 8'hFB;
  localparam logic [7:0]  C_TERM  = 8'hFD;
  localparam logic [15:0] MIN_L   = 16'(MIN_LEN);
  localparam logic [15:0] MAX_L   = 16'(MAX_LEN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRE,
    S_DATA
  } state_t;

  state_t           st_q, st_d;
  logic [2:0]       pcnt_q, pcnt_d;
  logic [15:0]      len_q, len_d;
  logic             perr_q, perr_d;
  logic             cerr_q, cerr_d;
`ifdef FRAME_CRC_CHECK_EN
  logic [31:0]      crc_q, crc_d;
  logic             crc_bad;
`endif

  logic [7:0]       b;
  logic             is_c, is_s, is_t, is_o;
  logic             cl, op;
  logic [15:0]      cl_len;
  logic [ERR_W-1:0] cl_err;

  logic [1:0]       ncl;
  logic [15:0]      c0_len, c1_len;
  logic [ERR_W-1:0] c0_err, c1_err;

  logic             pend_v_q;
  logic [15:0]      pend_len_q;
  logic [ERR_W-1:0] pend_err_q;
  logic             push;

  function automatic logic [ERR_W-1:0] mk_err(
    input logic [15:0] ln,
    input logic        pe,
    input logic        ce,
    input logic        nt
  );
    logic [ERR_W-1:0] e;
    e    = '0;
    e[0] = pe;
    e[1] = ln < MIN_L;
    e[2] = ln > MAX_L;
    e[3] = ce;
    e[4] = nt;
    return e;
  endfunction

`ifdef FRAME_CRC_CHECK_EN
  function automatic logic [31:0] crc_byte(
    input logic [31:0] c,
    input logic [7:0]  d
  );
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction
`endif

  // Walk the lanes in wire order; each lane may close and/or
  // open a frame, so up to two closes land in one word.
  always_comb begin
    st_d   = st_q;
    pcnt_d = pcnt_q;
    len_d  = len_q;
    perr_d = perr_q;
    cerr_d = cerr_q;
`ifdef FRAME_CRC_CHECK_EN
    crc_d   = crc_q;
    crc_bad = 1'b0;
`endif
    b      = '0;
    is_c   = 1'b0;
    is_s   = 1'b0;
    is_t   = 1'b0;
    is_o   = 1'b0;
    cl     = 1'b0;
    op     = 1'b0;
    cl_len = '0;
    cl_err = '0;
    ncl    = '0;
    c0_len = '0;
    c0_err = '0;
    c1_len = '0;
    c1_err = '0;
    for (int k = 0; k < LANES; k++) begin
      b    = xd_i[8*k +: 8];
      is_c = xc_i[k];
      is_s = is_c && (b == C_START);
      is_t = is_c && (b == C_TERM);
      is_o = is_c && !is_s && !is_t;
      cl     = 1'b0;
      op     = 1'b0;
      cl_len = '0;
      cl_err = '0;
`ifdef FRAME_CRC_CHECK_EN
      crc_bad = crc_d != CRC_MAGIC;
`endif
      unique case (st_d)
        S_IDLE: op = is_s;
        S_PRE: begin
          unique case (1'b1)
            is_t: begin
              cl     = 1'b1;
              cl_err = mk_err(16'd0, 1'b1, cerr_d, 1'b0);
              st_d   = S_IDLE;
            end
            is_s: begin
              cl     = 1'b1;
              cl_len = len_d;
              cl_err = mk_err(len_d, perr_d, cerr_d, 1'b1);
              op     = 1'b1;
            end
            default: begin
              if (is_c || b != ((pcnt_d == 3'd6) ? 8'hD5 : 8'h55))
                perr_d = 1'b1;
              if (pcnt_d == 3'd6)
                st_d = S_DATA;
              else
                pcnt_d = pcnt_d + 3'd1;
            end
          endcase
        end
        S_DATA: begin
          unique case (1'b1)
            is_t: begin
              cl     = 1'b1;
              cl_len = len_d;
              cl_err = mk_err(len_d, perr_d, cerr_d, 1'b0);
              st_d   = S_IDLE;
            end
            is_s: begin
              cl     = 1'b1;
              cl_len = len_d;
              cl_err = mk_err(len_d, perr_d, cerr_d, 1'b1);
              op     = 1'b1;
            end
            is_o: cerr_d = 1'b1;
            default: begin
              if (len_d != 16'hFFFF)
                len_d = len_d + 16'd1;
`ifdef FRAME_CRC_CHECK_EN
              crc_d = crc_byte(crc_d, b);
`endif
            end
          endcase
        end
        default: st_d = S_IDLE;
      endcase
`ifdef FRAME_CRC_CHECK_EN
      if (cl)
        cl_err[5] = crc_bad;
`endif
      if (op) begin
        st_d   = S_PRE;
        pcnt_d = '0;
        len_d  = '0;
        perr_d = 1'b0;
        cerr_d = 1'b0;
`ifdef FRAME_CRC_CHECK_EN
        crc_d  = '1;
`endif
      end
      if (cl) begin
        if (ncl == 2'd0) begin
          c0_len = cl_len;
          c0_err = cl_err;
        end else if (ncl == 2'd1) begin
          c1_len = cl_len;
          c1_err = cl_err;
        end
        if (ncl != 2'd3)
          ncl = ncl + 2'd1;
      end
    end
    // Disabled: drop any frame in flight without a record.
    if (!en_i) begin
      st_d   = S_IDLE;
      pcnt_d = '0;
      len_d  = '0;
      perr_d = 1'b0;
      cerr_d = 1'b0;
`ifdef FRAME_CRC_CHECK_EN
      crc_d  = '1;
`endif
      ncl    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= S_IDLE;
      pcnt_q <= '0;
      len_q  <= '0;
      perr_q <= 1'b0;
      cerr_q <= 1'b0;
`ifdef FRAME_CRC_CHECK_EN
      crc_q  <= '1;
`endif
    end else begin
      st_q   <= st_d;
      pcnt_q <= pcnt_d;
      len_q  <= len_d;
      perr_q <= perr_d;
      cerr_q <= cerr_d;
`ifdef FRAME_CRC_CHECK_EN
      crc_q  <= crc_d;
`endif
    end
  end

  assign push = pend_v_q || (ncl != 2'd0);

  // A held record always goes out first; the word's own
  // first close then takes the pending slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_done_o <= 1'b0;
      frame_len_o  <= '0;
      frame_err_o  <= '0;
      pend_v_q     <= 1'b0;
      pend_len_q   <= '0;
      pend_err_q   <= '0;
    end else begin
      frame_done_o <= push;
      if (pend_v_q) begin
        frame_len_o <= pend_len_q;
        frame_err_o <= pend_err_q;
        pend_v_q    <= ncl != 2'd0;
        pend_len_q  <= c0_len;
        pend_err_q  <= c0_err;
      end else begin
        if (ncl != 2'd0) begin
          frame_len_o <= c0_len;
          frame_err_o <= c0_err;
        end
        pend_v_q   <= ncl >= 2'd2;
        pend_len_q <= c1_len;
        pend_err_q <= c1_err;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      good_cnt_o <= '0;
      bad_cnt_o  <= '0;
    end else if (clr_i) begin
      good_cnt_o <= '0;
      bad_cnt_o  <= '0;
    end else if (frame_done_o) begin
      if (frame_err_o == '0) begin
        if (good_cnt_o != '1)
          good_cnt_o <= good_cnt_o + CNT_W'(1);
      end else begin
        if (bad_cnt_o != '1)
          bad_cnt_o <= bad_cnt_o + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_xgmii_frame_checker.sv
// tb_xgmii_frame_checker: directed bench, one 8-lane and one
// 4-lane checker instance driven from a byte queue.

module tb_xgmii_frame_checker;

`ifdef FRAME_CRC_CHECK_EN
  localparam int ERR_W = 6;
  localparam int E5    = 32;
`else
  localparam int ERR_W = 5;
  localparam int E5    = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n, en8, en4, clr8, clr4;
  logic [7:0]       xc8;
  logic [63:0]      xd8;
  logic [3:0]       xc4;
  logic [31:0]      xd4;
  logic             done8, done4;
  logic [15:0]      len8, len4;
  logic [ERR_W-1:0] err8, err4;
  logic [31:0]      good8, bad8, good4, bad4;

  xgmii_frame_checker #(.LANES(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .en_i(en8), .clr_i(clr8),
    .xc_i(xc8), .xd_i(xd8),
    .frame_done_o(done8), .frame_len_o(len8),
    .frame_err_o(err8),
    .good_cnt_o(good8), .bad_cnt_o(bad8)
  );

  xgmii_frame_checker #(.LANES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .en_i(en4), .clr_i(clr4),
    .xc_i(xc4), .xd_i(xd4),
    .frame_done_o(done4), .frame_len_o(len4),
    .frame_err_o(err4),
    .good_cnt_o(good4), .bad_cnt_o(bad4)
  );

  typedef struct {
    int len;
    int err;
    int at;
  } rec_t;

  rec_t       rec8[$];
  rec_t       rec4[$];
  bit         qc[$];
  logic [7:0] qd[$];
  int         widx, t_widx, last_at;
  int         n_cmp, n_bad;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    rec_t r;
    if (done8 === 1'b1) begin
      r.len = int'(len8);
      r.err = int'(err8);
      r.at  = widx - 1;
      rec8.push_back(r);
    end
    if (done4 === 1'b1) begin
      r.len = int'(len4);
      r.err = int'(err4);
      r.at  = widx - 1;
      rec4.push_back(r);
    end
  end

  function automatic logic [31:0] crc_step(input logic [31:0] c,
                                           input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  task automatic add(input bit c, input logic [7:0] d);
    qc.push_back(c);
    qd.push_back(d);
  endtask

  task automatic align(input int lanes);
    while (qc.size() % lanes != 0)
      add(1'b1, 8'h07);
  endtask

  task automatic pre(input bit badpre);
    add(1'b1, 8'hFB);
    for (int i = 0; i < 6; i++)
      add(1'b0, (badpre && i == 3) ? 8'h54 : 8'h55);
    add(1'b0, 8'hD5);
  endtask

  // len counts payload + 4-byte FCS; err_at >= 0 inserts an
  // ERROR control after that payload byte.
  task automatic frame(input int len, input bit badpre,
                       input bit flip, input int err_at);
    logic [31:0] c;
    logic [7:0]  b;
    c = 32'hFFFFFFFF;
    pre(badpre);
    for (int i = 0; i < len - 4; i++) begin
      b = 8'(i * 37 + 11);
      add(1'b0, b);
      c = crc_step(c, b);
      if (i == err_at)
        add(1'b1, 8'hFE);
    end
    c = ~c;
    if (flip)
      c[3] = ~c[3];
    for (int i = 0; i < 4; i++)
      add(1'b0, c[8*i +: 8]);
    add(1'b1, 8'hFD);
  endtask

  task automatic trunc(input int n);
    pre(1'b0);
    for (int i = 0; i < n; i++)
      add(1'b0, 8'(i + 1));
  endtask

  task automatic send(input int lanes);
    int         nw;
    bit         c;
    logic [7:0] d;
    align(lanes);
    repeat (4 * lanes) add(1'b1, 8'h07);
    nw = qc.size() / lanes;
    for (int w = 0; w < nw; w++) begin
      @(posedge clk);
      #1;
      widx++;
      for (int k = 0; k < lanes; k++) begin
        c = qc.pop_front();
        d = qd.pop_front();
        if (c && d == 8'hFD)
          t_widx = widx;
        if (lanes == 8) begin
          xc8[k]       = c;
          xd8[8*k +: 8] = d;
        end else begin
          xc4[k]       = c;
          xd4[8*k +: 8] = d;
        end
      end
    end
  endtask

  task automatic pop(input int dut, input string tag,
                     input int len, input int err);
    rec_t r;
    int   n;
    n = (dut == 8) ? rec8.size() : rec4.size();
    chk({tag, "_have"}, 32'(n > 0), 32'd1);
    if (n > 0) begin
      if (dut == 8)
        r = rec8.pop_front();
      else
        r = rec4.pop_front();
      chk({tag, "_len"}, r.len, len);
      chk({tag, "_err"}, r.err, err);
      last_at = r.at;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit hit");
    $fatal(1);
  end

  initial begin
    int a0;
    bit hit;
    n_cmp  = 0;
    n_bad  = 0;
    widx   = 0;
    t_widx = -1;
    rst_n  = 1'b0;
    en8    = 1'b1;
    en4    = 1'b1;
    clr8   = 1'b0;
    clr4   = 1'b0;
    xc8    = '1;
    xd8    = {8{8'h07}};
    xc4    = '1;
    xd4    = {4{8'h07}};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_done8", 32'(done8), 0);
    chk("rst_len8", 32'(len8), 0);
    chk("rst_err8", 32'(err8), 0);
    chk("rst_good8", good8, 0);
    chk("rst_bad8", bad8, 0);
    chk("rst_done4", 32'(done4), 0);
    chk("rst_good4", good4, 0);
    rst_n = 1'b1;

    // good 64-byte frame, T in lane 0, one-cycle latency
    frame(64, 1'b0, 1'b0, -1);
    send(8);
    pop(8, "good64", 64, 0);
    chk("good64_lat", last_at, t_widx);
    chk("good64_gcnt", good8, 1);
    chk("good64_bcnt", bad8, 0);

    // bad preamble byte
    frame(100, 1'b1, 1'b0, -1);
    send(8);
    pop(8, "badpre", 100, 1);
    chk("badpre_bcnt", bad8, 1);

    // short then long
    frame(40, 1'b0, 1'b0, -1);
    frame(1600, 1'b0, 1'b0, -1);
    send(8);
    pop(8, "short", 40, 2);
    pop(8, "long", 1600, 4);
    chk("sl_bcnt", bad8, 3);

    // ERROR code, then START mid-DATA, then a clean frame
    frame(64, 1'b0, 1'b0, 20);
    trunc(30);
    frame(64, 1'b0, 1'b0, -1);
    send(8);
    pop(8, "ctrl", 64, 8);
    pop(8, "noterm", 30, 16 + 2 + E5);
    pop(8, "after", 64, 0);
    chk("ct_gcnt", good8, 2);
    chk("ct_bcnt", bad8, 5);

    // two closes in one word: START mid-DATA, then T in PRE
    align(8);
    trunc(28);
    add(1'b1, 8'hFB);
    add(1'b0, 8'h55);
    add(1'b1, 8'hFD);
    send(8);
    pop(8, "dbl_a", 28, 16 + 2 + E5);
    a0 = last_at;
    pop(8, "dbl_b", 0, 3 + E5);
    chk("dbl_pend", last_at, a0 + 1);
    chk("dbl_bcnt", bad8, 7);

    // 4-lane good frame
    frame(64, 1'b0, 1'b0, -1);
    send(4);
    pop(4, "l4_good", 64, 0);
    chk("l4_gcnt", good4, 1);

    // clear on the same cycle as frame_done
    frame(64, 1'b0, 1'b0, -1);
    fork
      send(4);
      begin
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
          @(negedge clk);
          hit = done4;
        end
        chk("clr_wait", 32'(hit), 1);
        clr4 = 1'b1;
        @(posedge clk);
        #1;
        clr4 = 1'b0;
      end
    join
    pop(4, "l4_clr", 64, 0);
    chk("l4_clr_gcnt", good4, 0);
    chk("l4_clr_bcnt", bad4, 0);

    // en_i dropped mid-frame: no record
    frame(100, 1'b0, 1'b0, -1);
    fork
      send(4);
      begin
        repeat (10) @(posedge clk);
        #2;
        en4 = 1'b0;
        @(posedge clk);
        #2;
        en4 = 1'b1;
      end
    join
    chk("en_norec", rec4.size(), 0);
    frame(64, 1'b0, 1'b0, -1);
    send(4);
    pop(4, "en_next", 64, 0);
    chk("en_gcnt", good4, 1);

`ifdef FRAME_CRC_CHECK_EN
    frame(64, 1'b0, 1'b1, -1);
    send(8);
    pop(8, "fcs", 64, 32);
    chk("fcs_bcnt", bad8, 8);
`endif

    chk("left8", rec8.size(), 0);
    chk("left4", rec4.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
